// File: rtl/mpu_store_stream_if.sv
// Memory-side element stream of the MPU store engine.
// Master drives elements with coordinates; slave returns ready.
interface mpu_store_stream_if #(
  parameter int FP    = 32,
  parameter int MBITS = 3,
  parameter int NBITS = 3
);
  logic             mem_valid_out;
  logic             mem_ready_in;
  logic [FP-1:0]    mem_element_out;
  logic [MBITS:0]   mem_i_out;
  logic [NBITS:0]   mem_j_out;
  logic             mem_last_out;
  logic [MBITS:0]   mem_m_store_size_out;
  logic [NBITS:0]   mem_n_store_size_out;

  modport master (
    output mem_valid_out,
    input  mem_ready_in,
    output mem_element_out,
    output mem_i_out,
    output mem_j_out,
    output mem_last_out,
    output mem_m_store_size_out,
    output mem_n_store_size_out
  );

  modport slave (
    input  mem_valid_out,
    output mem_ready_in,
    input  mem_element_out,
    input  mem_i_out,
    input  mem_j_out,
    input  mem_last_out,
    input  mem_m_store_size_out,
    input  mem_n_store_size_out
  );
endinterface

// File: rtl/mpu_store_stream.sv
// MPU store engine: streams one register-file matrix to memory,
// row-major or transposed, through a 2-entry output buffer.
module mpu_store_stream #(
  parameter int FP              = 32,
  parameter int MBITS           = 3,
  parameter int NBITS           = 3,
  parameter int MATRIX_REG_SIZE = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       store_en_in,
  input  logic [MATRIX_REG_SIZE-1:0] store_addr_in,
  input  logic                       transpose_in,
  input  logic [MBITS:0]             reg_m_store_size_in,
  input  logic [NBITS:0]             reg_n_store_size_in,
  output logic                       reg_rd_en_out,
  output logic [MATRIX_REG_SIZE-1:0] reg_store_addr_out,
  output logic [MBITS:0]             reg_i_store_loc_out,
  output logic [NBITS:0]             reg_j_store_loc_out,
  input  logic [FP-1:0]              reg_element_in,
  mpu_store_stream_if.master         mem,
  output logic                       busy_out,
  output logic                       done_out,
  output logic                       error_out
);
  typedef enum logic [1:0] {
    IDLE, RUN, DRAIN, DONE
  } state_t;

  localparam logic [MBITS:0] ONE_M = (MBITS+1)'(1);
  localparam logic [NBITS:0] ONE_N = (NBITS+1)'(1);
  localparam logic [MBITS:0] MAX_M = ONE_M << MBITS;
  localparam logic [NBITS:0] MAX_N = ONE_N << NBITS;

  state_t                     state;
  logic [MATRIX_REG_SIZE-1:0] addr_q;
  logic                       tr_q;
  logic [MBITS:0]             m_q, i_q;
  logic [NBITS:0]             n_q, j_q;
  logic                       err_q;

  logic                       fl_q, fl_last;
  logic [MBITS:0]             fl_i;
  logic [NBITS:0]             fl_j;

  logic [FP-1:0]              b_e [2];
  logic [MBITS:0]             b_i [2];
  logic [NBITS:0]             b_j [2];
  logic                       b_l [2];
  logic                       rd_p, wr_p;
  logic [1:0]                 cnt;

  logic vld, pop, issue, i_end, j_end, last_rd, bad;

  assign vld     = cnt != 2'd0;
  assign pop     = vld & mem.mem_ready_in;
  assign i_end   = i_q == m_q - ONE_M;
  assign j_end   = j_q == n_q - ONE_N;
  assign last_rd = i_end & j_end;
  // Count the read returning now so the buffer can never overflow.
  assign issue   = (state == RUN) &&
                   ((cnt + {1'b0, fl_q} - {1'b0, pop}) < 2'd2);
  assign bad     = (reg_m_store_size_in == '0) ||
                   (reg_n_store_size_in == '0) ||
                   (reg_m_store_size_in > MAX_M) ||
                   (reg_n_store_size_in > MAX_N);

  assign reg_rd_en_out       = issue;
  assign reg_store_addr_out  = addr_q;
  assign reg_i_store_loc_out = i_q;
  assign reg_j_store_loc_out = j_q;

  assign mem.mem_valid_out        = vld;
  assign mem.mem_element_out      = vld ? b_e[rd_p] : '0;
  assign mem.mem_i_out            = vld ? b_i[rd_p] : '0;
  assign mem.mem_j_out            = vld ? b_j[rd_p] : '0;
  assign mem.mem_last_out         = vld ? b_l[rd_p] : 1'b0;
  assign mem.mem_m_store_size_out = m_q;
  assign mem.mem_n_store_size_out = n_q;

  assign busy_out  = (state == RUN) || (state == DRAIN);
  assign done_out  = state == DONE;
  assign error_out = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      tr_q    <= 1'b0;
      m_q     <= '0;
      n_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      err_q   <= 1'b0;
      fl_q    <= 1'b0;
      fl_last <= 1'b0;
      fl_i    <= '0;
      fl_j    <= '0;
      rd_p    <= 1'b0;
      wr_p    <= 1'b0;
      cnt     <= '0;
    end else begin
      err_q <= 1'b0;
      fl_q  <= issue;
      if (issue) begin
        fl_i    <= i_q;
        fl_j    <= j_q;
        fl_last <= last_rd;
      end
      if (fl_q) begin
        b_e[wr_p] <= reg_element_in;
        b_i[wr_p] <= fl_i;
        b_j[wr_p] <= fl_j;
        b_l[wr_p] <= fl_last;
        wr_p      <= ~wr_p;
      end
      if (pop) rd_p <= ~rd_p;
      cnt <= cnt + {1'b0, fl_q} - {1'b0, pop};

      unique case (state)
        IDLE: begin
          if (store_en_in) begin
            if (bad) begin
              err_q <= 1'b1;
            end else begin
              addr_q <= store_addr_in;
              tr_q   <= transpose_in;
              m_q    <= reg_m_store_size_in;
              n_q    <= reg_n_store_size_in;
              i_q    <= '0;
              j_q    <= '0;
              state  <= RUN;
            end
          end
        end
        RUN: begin
          if (issue) begin
            if (last_rd) begin
              state <= DRAIN;
            end else if (!tr_q) begin
              if (j_end) begin
                j_q <= '0;
                i_q <= i_q + ONE_M;
              end else begin
                j_q <= j_q + ONE_N;
              end
            end else begin
              if (i_end) begin
                i_q <= '0;
                j_q <= j_q + ONE_N;
              end else begin
                i_q <= i_q + ONE_M;
              end
            end
          end
        end
        DRAIN: begin
          if (pop && b_l[rd_p]) state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mpu_store_stream.sv
// Bench for mpu_store_stream: queue model of the element stream
// plus hand-computed cycle and ordering expectations.
module tb_mpu_store_stream;
  localparam int FP = 32;
  localparam int MB = 3;
  localparam int NB = 3;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          store_en_in;
  logic [AW-1:0] store_addr_in;
  logic          transpose_in;
  logic [MB:0]   m_in;
  logic [NB:0]   n_in;
  logic          reg_rd_en_out;
  logic [AW-1:0] reg_store_addr_out;
  logic [MB:0]   reg_i;
  logic [NB:0]   reg_j;
  logic [FP-1:0] reg_element_in = '0;
  logic          busy_out, done_out, error_out;

  always #5 clk = ~clk;

  mpu_store_stream_if #(.FP(FP), .MBITS(MB), .NBITS(NB)) mif ();

  mpu_store_stream #(
    .FP(FP), .MBITS(MB), .NBITS(NB), .MATRIX_REG_SIZE(AW)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .store_en_in         (store_en_in),
    .store_addr_in       (store_addr_in),
    .transpose_in        (transpose_in),
    .reg_m_store_size_in (m_in),
    .reg_n_store_size_in (n_in),
    .reg_rd_en_out       (reg_rd_en_out),
    .reg_store_addr_out  (reg_store_addr_out),
    .reg_i_store_loc_out (reg_i),
    .reg_j_store_loc_out (reg_j),
    .reg_element_in      (reg_element_in),
    .mem                 (mif),
    .busy_out            (busy_out),
    .done_out            (done_out),
    .error_out           (error_out)
  );

  typedef struct {
    logic [31:0] e;
    int          i;
    int          j;
    bit          last;
  } exp_t;

  exp_t exp_q[$];
  int   rx_i[$], rx_j[$], rx_t[$];
  int   n_cmp = 0, n_err = 0;
  int   cyc = 0, start_cyc = 0;
  int   stall_lo = 1, stall_hi = 0;
  int   first_valid = -1, done_cyc = -1, err_cyc = -1;
  int   done_count = 0, err_count = 0, rd_count = 0, busy_count = 0;
  int   issued = 0, popped = 0;
  bit   prev_stall = 0;
  logic [63:0] prev_head = '0;
  logic [MB:0] exp_m = '0;
  logic [NB:0] exp_n = '0;

  function automatic logic [31:0] rf(int a, int i, int j);
    return 32'hC0DE_0000 | 32'(a << 12) | 32'(i << 4) | 32'(j);
  endfunction

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Register file: data valid the cycle after the read strobe.
  always @(posedge clk)
    if (reg_rd_en_out)
      reg_element_in <= rf(int'(reg_store_addr_out), int'(reg_i),
                           int'(reg_j));

  always @(posedge clk) begin
    #1;
    mif.mem_ready_in = !((cyc - start_cyc) >= stall_lo &&
                         (cyc - start_cyc) <= stall_hi);
  end

  always @(negedge clk) begin
    int   rel;
    exp_t x;
    rel = cyc - start_cyc;
    if (rst === 1'b0) begin
      if (reg_rd_en_out) begin
        issued++;
        rd_count++;
        chk("outstanding_le_3", 1'(issued - popped <= 3), 1'b1);
        chk("rd_only_busy", busy_out, 1'b1);
      end
      if (busy_out) begin
        busy_count++;
        chk("m_size_held", mif.mem_m_store_size_out, exp_m);
        chk("n_size_held", mif.mem_n_store_size_out, exp_n);
      end
      if (prev_stall) begin
        chk("stall_valid", mif.mem_valid_out, 1'b1);
        chk("stall_head", {mif.mem_element_out, mif.mem_i_out,
            mif.mem_j_out, mif.mem_last_out}, prev_head);
      end
      if (mif.mem_valid_out && first_valid < 0) first_valid = rel;
      if (mif.mem_valid_out && mif.mem_ready_in) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_elem", 1'b1, 1'b0);
        end else begin
          x = exp_q.pop_front();
          chk("elem_data", mif.mem_element_out, x.e);
          chk("elem_i", mif.mem_i_out, x.i);
          chk("elem_j", mif.mem_j_out, x.j);
          chk("elem_last", mif.mem_last_out, x.last);
        end
        rx_i.push_back(int'(mif.mem_i_out));
        rx_j.push_back(int'(mif.mem_j_out));
        rx_t.push_back(rel);
        popped++;
      end
      prev_stall = mif.mem_valid_out && !mif.mem_ready_in;
      prev_head  = {mif.mem_element_out, mif.mem_i_out,
                    mif.mem_j_out, mif.mem_last_out};
      if (done_out) begin
        done_count++;
        done_cyc = rel;
      end
      if (error_out) begin
        err_count++;
        err_cyc = rel;
      end
    end
  end

  task automatic start(input int m, input int n, input bit tr,
                       input int a);
    exp_t x;
    @(negedge clk);
    #1;
    first_valid = -1;
    done_cyc    = -1;
    err_cyc     = -1;
    rx_i.delete();
    rx_j.delete();
    rx_t.delete();
    if (m >= 1 && m <= 8 && n >= 1 && n <= 8) begin
      exp_m = (MB+1)'(m);
      exp_n = (NB+1)'(n);
      for (int k = 0; k < m * n; k++) begin
        x.i    = tr ? k % m : k / n;
        x.j    = tr ? k / m : k % n;
        x.e    = rf(a, x.i, x.j);
        x.last = (k == m * n - 1);
        exp_q.push_back(x);
      end
    end
    start_cyc     = cyc;
    store_en_in   = 1'b1;
    m_in          = (MB+1)'(m);
    n_in          = (NB+1)'(n);
    transpose_in  = tr;
    store_addr_in = AW'(a);
    @(negedge clk);
    #1;
    store_en_in = 1'b0;
  endtask

  task automatic wait_rel(input int r);
    for (int c = 0; c < 200 && (cyc - start_cyc) < r; c++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_done(input string nm, input int d0);
    for (int c = 0; c < 300 && done_count == d0; c++) @(negedge clk);
    chk({nm, "_done_seen"}, 1'(done_count == d0 + 1), 1'b1);
    @(negedge clk);
    #1;
    chk({nm, "_queue_empty"}, exp_q.size(), 0);
  endtask

  initial begin : main
    int d0, r0, b0, e0;
    int ri[6], rj[6], ti[6], tj[6];
    ri = '{0, 0, 0, 1, 1, 1};
    rj = '{0, 1, 2, 0, 1, 2};
    ti = '{0, 1, 0, 1, 0, 1};
    tj = '{0, 0, 1, 1, 2, 2};
    rst = 1'b1;
    store_en_in = 1'b0;
    store_addr_in = '0;
    transpose_in = 1'b0;
    m_in = '0;
    n_in = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", {reg_rd_en_out, reg_store_addr_out, reg_i, reg_j,
        mif.mem_valid_out, mif.mem_element_out, mif.mem_i_out,
        mif.mem_j_out, mif.mem_last_out, mif.mem_m_store_size_out,
        mif.mem_n_store_size_out, busy_out, done_out, error_out}, '0);
    rst = 1'b0;

    // 2x3 row-major, with an ignored start request mid-transfer
    d0 = done_count;
    r0 = rd_count;
    start(2, 3, 1'b0, 1);
    wait_rel(3);
    store_en_in = 1'b1;
    m_in = 4'd1;
    n_in = 4'd1;
    transpose_in = 1'b1;
    @(negedge clk);
    #1;
    store_en_in = 1'b0;
    wait_done("t1", d0);
    chk("t1_first_valid", first_valid, 3);
    chk("t1_done_cycle", done_cyc, 9);
    chk("t1_reads", rd_count - r0, 6);
    chk("t1_count", rx_i.size(), 6);
    for (int k = 0; k < 6 && k < rx_i.size(); k++) begin
      chk($sformatf("t1_i%0d", k), rx_i[k], ri[k]);
      chk($sformatf("t1_j%0d", k), rx_j[k], rj[k]);
      chk($sformatf("t1_t%0d", k), rx_t[k], 3 + k);
    end

    // 2x3 transpose
    d0 = done_count;
    start(2, 3, 1'b1, 2);
    wait_done("t2", d0);
    chk("t2_done_cycle", done_cyc, 9);
    chk("t2_count", rx_i.size(), 6);
    for (int k = 0; k < 6 && k < rx_i.size(); k++) begin
      chk($sformatf("t2_i%0d", k), rx_i[k], ti[k]);
      chk($sformatf("t2_j%0d", k), rx_j[k], tj[k]);
    end

    // 3x3 with the sink stalled on cycles 4..7
    d0 = done_count;
    stall_lo = 4;
    stall_hi = 7;
    start(3, 3, 1'b0, 0);
    wait_done("t3", d0);
    stall_lo = 1;
    stall_hi = 0;
    chk("t3_count", rx_i.size(), 9);
    chk("t3_done_cycle", done_cyc, 16);
    if (rx_t.size() >= 2) chk("t3_second_elem_cycle", rx_t[1], 8);

    // 1x1
    d0 = done_count;
    start(1, 1, 1'b0, 3);
    wait_done("t4", d0);
    chk("t4_count", rx_i.size(), 1);
    if (rx_t.size() >= 1) chk("t4_elem_cycle", rx_t[0], 3);
    chk("t4_done_cycle", done_cyc, 4);

    // rejected sizes: 0 rows, 9 rows, 9 columns
    for (int t = 0; t < 3; t++) begin
      d0 = done_count;
      r0 = rd_count;
      b0 = busy_count;
      e0 = err_count;
      start(t == 0 ? 0 : (t == 1 ? 9 : 2), t == 2 ? 9 : 3, 1'b0, 1);
      repeat (4) @(negedge clk);
      #1;
      chk($sformatf("t5_%0d_err_cycle", t), err_cyc, 1);
      chk($sformatf("t5_%0d_err_pulses", t), err_count - e0, 1);
      chk($sformatf("t5_%0d_no_reads", t), rd_count - r0, 0);
      chk($sformatf("t5_%0d_no_busy", t), busy_count - b0, 0);
      chk($sformatf("t5_%0d_no_done", t), done_count - d0, 0);
    end

    // reset in the middle of a 4x4, then a clean 2x2
    d0 = done_count;
    start(4, 4, 1'b0, 2);
    wait_rel(8);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("t6_reset_outputs", {reg_rd_en_out, reg_store_addr_out, reg_i,
        reg_j, mif.mem_valid_out, mif.mem_element_out, mif.mem_i_out,
        mif.mem_j_out, mif.mem_last_out, mif.mem_m_store_size_out,
        mif.mem_n_store_size_out, busy_out, done_out, error_out}, '0);
    rst = 1'b0;
    exp_q.delete();
    issued = 0;
    popped = 0;
    prev_stall = 0;
    repeat (10) @(negedge clk);
    #1;
    chk("t6_no_done", done_count - d0, 0);
    d0 = done_count;
    start(2, 2, 1'b0, 3);
    wait_done("t7", d0);
    chk("t7_count", rx_i.size(), 4);
    chk("t7_done_cycle", done_cyc, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end
endmodule
